// File: rtl/video_pkg.sv
// Shared video types and constants for the pixel fetch path.
// PIXEL_FETCH_UNDERFLOW_COLOR_EN selects a magenta starvation pixel.
package video_pkg;

  typedef logic [15:0] rgb565_t;

  localparam int H_DISP_DEF   = 1280;
  localparam int V_DISP_DEF   = 800;
  localparam int FRAME_PIXELS = H_DISP_DEF * V_DISP_DEF;

  localparam rgb565_t UF_PIX_MAGENTA = 16'hF81F;
  localparam rgb565_t UF_PIX_BLACK   = 16'h0000;

`ifdef PIXEL_FETCH_UNDERFLOW_COLOR_EN
  localparam rgb565_t UNDERFLOW_PIXEL = UF_PIX_MAGENTA;
`else
  localparam rgb565_t UNDERFLOW_PIXEL = UF_PIX_BLACK;
`endif

  typedef enum logic [1:0] {
    SEEK,
    FILL,
    RUN
  } fetch_state_t;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with flush, full/empty and registered read data.
// Pointers carry one wrap bit beyond the address.
module sync_fifo #(
  parameter int W     = 17,
  parameter int DEPTH = 2048,
  parameter int AW    = 11
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         flush,
  input  logic         wr_en,
  input  logic [W-1:0] wr_data,
  input  logic         rd_en,
  output logic [W-1:0] rd_data,
  output logic         full,
  output logic         empty
);

  logic [W-1:0] mem [DEPTH];
  logic [AW:0]  wr_ptr_q, wr_ptr_d;
  logic [AW:0]  rd_ptr_q, rd_ptr_d;
  logic [W-1:0] rd_data_q, rd_data_d;
  logic         do_wr, do_rd;

  assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                 (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign empty = (wr_ptr_q == rd_ptr_q);
  assign rd_data = rd_data_q;

  always_comb begin
    do_wr     = wr_en & ~full & ~flush;
    do_rd     = rd_en & ~empty & ~flush;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    rd_data_d = rd_data_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      if (do_wr) wr_ptr_d = wr_ptr_q + 1'b1;
      if (do_rd) begin
        rd_ptr_d  = rd_ptr_q + 1'b1;
        rd_data_d = mem[rd_ptr_q[AW-1:0]];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr_q[AW-1:0]] <= wr_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      rd_data_q <= '0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      rd_data_q <= rd_data_d;
    end
  end

endmodule

// File: rtl/pixel_fetch_buffer.sv
// Elastic pixel buffer feeding the HDMI timing driver, frame-locked to vsync.
// PIXEL_FETCH_UNDERFLOW_COLOR_EN (via video_pkg) picks the starvation pixel.
module pixel_fetch_buffer
  import video_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 2048,
  parameter int AW     = 11,
  parameter int H_DISP = H_DISP_DEF,
  parameter int V_DISP = V_DISP_DEF
) (
  input  logic              pixel_clk,
  input  logic              sys_rst_n,
  input  logic [DATA_W-1:0] s_data,
  input  logic              s_valid,
  input  logic              s_sof,
  output logic              s_ready,
  input  logic              video_vs,
  input  logic              data_req,
  output logic [DATA_W-1:0] video_rgb_565,
  output logic              frame_locked,
  output logic [15:0]       underflow_cnt
);

  localparam logic [20:0] FRAME_N = 21'(H_DISP * V_DISP);
  localparam int          FW      = DATA_W + 1;
  localparam rgb565_t     UF_PIX  = UNDERFLOW_PIXEL;

  fetch_state_t      state_q, state_d;
  logic              vs_q, vs_fall;
  logic              rdy_en_q;
  logic [20:0]       served_q, served_d;
  logic              err_q, err_d, err_now;
  logic              chk_q, chk_d;
  logic              sel_q, sel_d;
  logic [DATA_W-1:0] pix_q, pix_d;
  logic [15:0]       ucnt_q, ucnt_d;
  logic              locked_q;
  logic              fifo_full, fifo_empty;
  logic              flush, push, pop, under;
  logic [FW-1:0]     fifo_rd;

  assign vs_fall = vs_q & ~video_vs;
  // a sof seen on last cycle's pop is folded in before the flag lands
  assign err_now = err_q | (chk_q & fifo_rd[DATA_W]);
  assign s_ready = rdy_en_q & ((state_q == SEEK) | ~fifo_full);

  assign video_rgb_565 = sel_q ? fifo_rd[DATA_W-1:0] : pix_q;
  assign frame_locked  = locked_q;
  assign underflow_cnt = ucnt_q;

  always_comb begin
    state_d  = state_q;
    served_d = served_q;
    err_d    = err_now;
    chk_d    = 1'b0;
    sel_d    = sel_q;
    pix_d    = pix_q;
    ucnt_d   = ucnt_q;
    flush    = 1'b0;
    push     = 1'b0;
    pop      = 1'b0;
    under    = 1'b0;
    unique case (state_q)
      SEEK: begin
        err_d = 1'b0;
        if (s_valid & s_ready & s_sof) begin
          push    = 1'b1;
          state_d = FILL;
        end
      end
      FILL: begin
        err_d = 1'b0;
        push  = s_valid & s_ready;
        if (vs_fall) begin
          state_d  = RUN;
          served_d = '0;
        end
      end
      RUN: begin
        push = s_valid & s_ready;
        if (data_req) begin
          served_d = served_q + 21'd1;
          under    = fifo_empty;
          pop      = ~fifo_empty;
          chk_d    = ~fifo_empty & (served_q != '0);
        end
        if (under) begin
          err_d = 1'b1;
          if (ucnt_q != 16'hFFFF) ucnt_d = ucnt_q + 16'd1;
        end
        if (vs_fall) begin
          served_d = '0;
          err_d    = 1'b0;
          if (served_q != FRAME_N || err_now) begin
            flush   = 1'b1;
            pop     = 1'b0;
            chk_d   = 1'b0;
            state_d = SEEK;
          end
        end
      end
      default: state_d = SEEK;
    endcase
    if (pop) begin
      sel_d = 1'b1;
    end else if (under) begin
      sel_d = 1'b0;
      pix_d = DATA_W'(UF_PIX);
    end
  end

  always_ff @(posedge pixel_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q  <= SEEK;
      vs_q     <= 1'b0;
      rdy_en_q <= 1'b0;
      served_q <= '0;
      err_q    <= 1'b0;
      chk_q    <= 1'b0;
      sel_q    <= 1'b0;
      pix_q    <= '0;
      ucnt_q   <= '0;
      locked_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      vs_q     <= video_vs;
      rdy_en_q <= 1'b1;
      served_q <= served_d;
      err_q    <= err_d;
      chk_q    <= chk_d;
      sel_q    <= sel_d;
      pix_q    <= pix_d;
      ucnt_q   <= ucnt_d;
      locked_q <= (state_d == RUN);
    end
  end

  sync_fifo #(
    .W     (FW),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_fifo (
    .clk     (pixel_clk),
    .rst_n   (sys_rst_n),
    .flush   (flush),
    .wr_en   (push),
    .wr_data ({s_sof, s_data}),
    .rd_en   (pop),
    .rd_data (fifo_rd),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

endmodule

// File: doc/pixel_fetch_buffer.md
Name: pixel_fetch_buffer

Overview:
Single-clock elastic buffer directly upstream of the HDMI video timing driver. It accepts an RGB565 pixel stream with a start-of-frame marker from the frame-read path (valid/ready), and stores it in a FIFO. It releases exactly one pixel per data_req pulse from the timing driver, aligned to that driver's frame boundary. It detects underflow and misalignment, flushes, and re-locks on the next frame.

Parameters:
DATA_W, 16, pixel width (RGB565)
DEPTH, 2048, FIFO depth in words; power of two
AW, 11, FIFO address width, log2(DEPTH)
H_DISP, 1280, active pixels per line
V_DISP, 800, active lines per frame

Ports:
pixel_clk  in  1  pixel clock; only clock
sys_rst_n  in  1  asynchronous active-low reset
s_data  in  16  upstream RGB565 pixel
s_valid  in  1  s_data valid
s_sof  in  1  s_data is first pixel of a frame
s_ready  out  1  buffer accepts s_data this cycle
video_vs  in  1  vertical sync from timing driver, active low
data_req  in  1  timing driver requests next pixel
video_rgb_565  out  16  pixel to timing driver
frame_locked  out  1  high while in RUN
underflow_cnt  out  16  saturating count of data_req cycles served while FIFO empty

Behaviour:
- Clock and reset: one clock, pixel_clk. Reset sys_rst_n is asynchronous, active-low. Reset values: video_rgb_565=0, s_ready=0, frame_locked=0, underflow_cnt=0, FIFO empty, served count=0, state=SEEK.
- FIFO: 17 bits wide, {sof, pixel}. Write when s_valid&&s_ready. Pop on data_req in RUN when not empty. Simultaneous push and pop allowed; count unchanged. No bypass: a pop on an empty FIFO is an underflow even if a push occurs in the same cycle.
- vs_fall: video_vs registered; vs_fall = previous 1 && current 0.
- State SEEK: s_ready=1. Words with s_sof=0 are dropped. A word with s_sof=1 is written, then go to FILL.
- State FILL: s_ready=!full. Writes continue. data_req is ignored and video_rgb_565 holds its value. On vs_fall go to RUN and clear served count.
- State RUN: s_ready=!full.
  - Each data_req pops one word. video_rgb_565 is registered with the popped pixel in the next cycle (latency 1) and held until the next pop.
  - data_req with FIFO empty: video_rgb_565 gets UNDERFLOW_PIXEL. underflow_cnt increments, saturating at 16'hFFFF. The frame-error flag is set.
  - Popped word has sof=1 while served count != 0: misalignment; set frame-error flag.
  - served count: 21 bits, increments on every data_req in RUN.
  - On vs_fall: if served count != H_DISP*V_DISP (1,024,000) or the frame-error flag is set, flush the FIFO and go to SEEK. Otherwise clear served count and the flag, and stay in RUN.
  - A misalignment pop does not abort the frame immediately; output continues until vs_fall.
- Flush: read and write pointers zeroed in one cycle. A push in that same cycle is discarded.
- frame_locked = (state==RUN), registered.
- Full: s_ready low; upstream must hold s_data. Pointers are AW+1 bits; full when MSBs differ and the rest are equal.
- Reset asserted mid-frame: all state is cleared immediately (asynchronous). After release, the block returns to SEEK.

Optional Feature:
- Macro: PIXEL_FETCH_UNDERFLOW_COLOR_EN.
- Defined: UNDERFLOW_PIXEL = 16'hF81F (magenta), so starvation is visible on screen.
- Undefined: UNDERFLOW_PIXEL = 16'h0000 (black).
- underflow_cnt and the resync logic are identical in both cases.

Decomposition:
- Package video_pkg holds:
  - rgb565_t typedef.
  - H_DISP/V_DISP defaults and FRAME_PIXELS constant.
  - UNDERFLOW_PIXEL values.
  - fetch_state_t enum {SEEK, FILL, RUN}.
- Sub-module sync_fifo: single-clock, parameterised width/depth, with a flush input, full/empty outputs and a registered read.

Test Plan:
- Reset, then stream 16 words with sof on the 4th word (s_valid constant) -> first 3 words dropped (s_ready=1); FIFO holds 13 words; state FILL; frame_locked=0.
- Prefill 2048 words -> s_ready=0 at full; held s_data is not lost; the next pop raises s_ready one cycle later.
- Lock after vs_fall, then data_req at cycle n popping pixel 16'h1234 -> video_rgb_565=16'h1234 at n+1, held until the next data_req.
- In RUN, FIFO empty when data_req pulses 3 times -> underflow_cnt=3; output 16'hF81F with macro, 16'h0000 without; at next vs_fall FIFO flushed, state SEEK, frame_locked=0.
- Full 1280x800 frame with a continuous feed, two frames -> no underflow; frame_locked stays 1; served count reaches 1,024,000 at each vs_fall.
- Inject an extra sof word mid-frame -> the frame completes; at vs_fall the block flushes and re-locks on the following frame.
